// File: rtl/uart_io_pkg.sv
// Shared definitions for the UART endpoint: default bit period and FSM state type.
package uart_io_pkg;
  localparam int unsigned UART_DIV = 868;

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} UART_STATE;
endpackage

// File: rtl/uart_io_if.sv
// CPU-side register view of the UART: TX store strobe, RX pop strobe and status words.
interface uart_io_if;
  logic        w_req;
  logic [7:0]  w_data;
  logic [31:0] w_busy;
  logic        r_ack;
  logic [31:0] r_data;
  logic        irr;

  modport master (output w_req, w_data, r_ack, input w_busy, r_data, irr);
  modport slave  (input w_req, w_data, r_ack, output w_busy, r_data, irr);
endinterface

// File: rtl/uart_io_rx.sv
// 8N1 receiver: synchronizes rx, samples mid-bit, pulses push for one cycle on a good stop bit.
module uart_rx
  import uart_io_pkg::*;
#(
  parameter int unsigned DIV = UART_DIV
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       push,
  output logic [7:0] data
);
  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

  logic          s1_q, s2_q, prev_q;
  UART_STATE     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= U_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      s1_q    <= rx;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  // A 1->0 edge is required to start, so after a framing error the line must return high first.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    push    = 1'b0;
    case (state_q)
      U_IDLE: begin
        if (prev_q && !s2_q) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = U_START;
        end
      end
      U_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = s2_q ? U_IDLE : U_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      U_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          sh_d  = {s2_q, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = U_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      U_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          push    = s2_q;
          state_d = U_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = U_IDLE;
    endcase
  end

  assign data = sh_q;
endmodule

// File: rtl/uart_io_tx.sv
// 8N1 transmitter: one start bit, eight data bits LSB-first, one stop bit, DIV clocks each.
module uart_tx
  import uart_io_pkg::*;
#(
  parameter int unsigned DIV = UART_DIV
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       w_req,
  input  logic [7:0] w_data,
  output logic       tx,
  output logic       busy
);
  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  UART_STATE     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= U_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx      = 1'b1;
    case (state_q)
      U_IDLE: begin
        if (w_req) begin
          sh_d    = w_data;
          cnt_d   = '0;
          state_d = U_START;
        end
      end
      U_START: begin
        tx = 1'b0;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = U_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      U_DATA: begin
        tx = sh_q[0];
        if (cnt_q == LAST) begin
          cnt_d = '0;
          sh_d  = sh_q >> 1;
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = U_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      U_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = U_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = U_IDLE;
    endcase
  end

  assign busy = (state_q != U_IDLE);
endmodule

// File: rtl/uart_io.sv
// Serial I/O endpoint: TX/RX engines plus the RX FIFO and status-word packing seen by the CPU.
module uart_io
  import uart_io_pkg::*;
#(
  parameter int unsigned DIV      = UART_DIV,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx,
  output logic      tx,
  uart_io_if.slave  bus
);
  localparam int unsigned AW = $clog2(RX_DEPTH);

  logic       tx_busy;
  logic       rx_push;
  logic [7:0] rx_byte;

  uart_tx #(.DIV(DIV)) u_tx (
    .clk    (clk),
    .reset  (reset),
    .w_req  (bus.w_req),
    .w_data (bus.w_data),
    .tx     (tx),
    .busy   (tx_busy)
  );

  uart_rx #(.DIV(DIV)) u_rx (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .push  (rx_push),
    .data  (rx_byte)
  );

  logic [7:0]    mem_q [RX_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovr_q, ovr_d;
  logic          empty, full, pop, wr_en, drop;

  // A pop frees the slot in the same cycle, so a push into a full FIFO with r_ack is not a drop.
  always_comb begin
    empty = (cnt_q == '0);
    full  = (cnt_q == (AW + 1)'(RX_DEPTH));
    pop   = bus.r_ack && !empty;
    wr_en = rx_push && (!full || pop);
    drop  = rx_push && full && !pop;
    cnt_d = cnt_q;
    if (wr_en && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !wr_en) cnt_d = cnt_q - 1'b1;
    ovr_d = ovr_q;
    if (drop)           ovr_d = 1'b1;
    else if (bus.r_ack) ovr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= rx_byte;
  end

  assign bus.w_busy = {31'b0, tx_busy};
  assign bus.r_data = {22'b0, ovr_q, !empty, empty ? 8'h00 : mem_q[rd_q]};
  assign bus.irr    = !empty;
endmodule
